// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped console transmitter.
// Holds the serialiser FSM state type, the bit layout of the 32-bit
// status word, and the default word addresses of the two registers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Status word layout: {22'b0, overflow, tx_busy, full, empty, count[5:0]}
    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_COUNT_W   = 6;
    localparam int STAT_EMPTY     = 6;
    localparam int STAT_FULL      = 7;
    localparam int STAT_BUSY      = 8;
    localparam int STAT_OVF       = 9;

    localparam logic [7:0] DEF_TX_ADDR     = 8'hFF;
    localparam logic [7:0] DEF_STATUS_ADDR = 8'hFE;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clock, clear  - rising-edge clock, asynchronous active-low reset
//   push, wdata   - write request and data; ignored while full
//   pop           - read request; ignored while empty
//   rdata         - current head entry, valid whenever empty is low
//   count         - number of stored entries (0..DEPTH)
//   full, empty   - occupancy flags derived from count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Both qualifiers use the pre-edge flags, so a push into a full FIFO is
    // dropped even when a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // NOTE: the storage array has no reset; the pointers and count fully
    // define which entries are valid, and a resettable array costs a mux per bit.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge values of its peers.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are log2(DEPTH) bits and wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped console transmitter snooping the MEM-stage store bus.
// Byte stores to TX_ADDR are queued in a FIFO and sent as 8N1 frames.
// Ports:
//   clock, clear - rising-edge clock, asynchronous active-low reset
//   wren, addr   - store enable and word address from the MEM stage
//   din          - store data; din[7:0] is the byte, din[9] clears overflow
//   status       - {22'b0, overflow, tx_busy, full, empty, count[5:0]}
//   tx           - registered UART line, idle high
//   tx_busy      - a frame is on the line
//   overflow     - sticky: a console store was dropped on a full FIFO
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] TX_ADDR      = DEF_TX_ADDR,
    parameter logic [7:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        wren,
    input  logic [7:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] status,
    output logic        tx,
    output logic        tx_busy,
    output logic        overflow
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e       state_q, state_n;
    logic [BW-1:0]   baud_q, baud_n;
    logic [2:0]      bit_q, bit_n;
    logic [7:0]      shift_q, shift_n;
    logic            tx_q, tx_n;
    logic            ovf_q;

    logic            push_req;
    logic            ovf_clear;
    logic            pop;
    logic [7:0]      head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            baud_done;
    logic            unused_din;

    assign push_req  = wren && (addr == TX_ADDR);
    assign ovf_clear = wren && (addr == STATUS_ADDR) && din[9];
    assign baud_done = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign unused_din = ^{din[31:10], din[8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .clear (clear),
        .push  (push_req),
        .pop   (pop),
        .wdata (din[7:0]),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_n = state_q;
        baud_n  = baud_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        tx_n    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_n = 1'b1;
                if (!fifo_empty) begin
                    // FWFT head lets the pop and the load share one edge.
                    pop     = 1'b1;
                    shift_n = head;
                    baud_n  = '0;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    tx_n    = shift_q[0];
                    state_n = DATA;
                end else begin
                    baud_n = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_n  = '0;
                    shift_n = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_n = bit_q + 3'd1;
                        // Registered line shows the bit the shift exposes next.
                        tx_n  = shift_q[1];
                    end
                end else begin
                    baud_n = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end else begin
                    baud_n = baud_q + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_n;
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            shift_q <= shift_n;
            tx_q    <= tx_n;
        end
    end

    // Set and clear come from different addresses, so they never collide.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            ovf_q <= 1'b0;
        end else if (push_req && fifo_full) begin
            ovf_q <= 1'b1;
        end else if (ovf_clear) begin
            ovf_q <= 1'b0;
        end
    end

    assign tx       = tx_q;
    assign tx_busy  = (state_q != IDLE);
    assign overflow = ovf_q;

    always_comb begin
        status = '0;
        status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_FULL]  = fifo_full;
        status[STAT_BUSY]  = tx_busy;
        status[STAT_OVF]   = ovf_q;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped console transmitter on the data-memory store path of the RV32 core. It snoops the MEM-stage store bus (address, data, write enable) and captures byte stores to a fixed console address into a small FIFO. It serialises FIFO contents as 8N1 UART frames on a single TX pin. Status is exposed as a 32-bit word that the DRAM read path multiplexes in at a status address.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 2
FIFO_DEPTH, 8, byte FIFO entries; power of two, 2..32
TX_ADDR, 8'hFF, word address of the console data register
STATUS_ADDR, 8'hFE, word address of the status/control register

Ports:
clock  in  1  system clock, all state on rising edge
clear  in  1  asynchronous active-low reset
wren  in  1  MEM-stage store enable
addr  in  8  MEM-stage store address (low 8 bits of ALU result)
din  in  32  MEM-stage store data; only din[7:0] is transmitted
status  out  32  {22'b0, overflow, tx_busy, full, empty, count[5:0]}
tx  out  1  UART serial output, idle high
tx_busy  out  1  high while a frame is on the line
overflow  out  1  sticky flag: a console store was dropped because the FIFO was full

Behaviour:
- Reset (clear low, asynchronous): FIFO empty, count=0, state IDLE, tx=1, tx_busy=0, overflow=0, baud and bit counters 0. Reset mid-frame aborts the frame and drives tx high immediately.
- Push: on edge where wren & addr==TX_ADDR.
  - Not full: din[7:0] is written at the write pointer, and count increments.
  - Full: the byte is dropped and overflow is set.
  - Full is evaluated from the pre-edge count. A push while full is dropped even if a pop occurs on the same edge.
- Push and pop on the same edge with FIFO neither full nor empty: both take effect, and count is unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits, zero-extended into status[5:0].
- Status write (wren & addr==STATUS_ADDR & din[9]): clears overflow. Other status bits are read-only. Stores to any other address are ignored.
- status is combinational from registered state. empty = (count==0); full = (count==FIFO_DEPTH).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty, pop the head into an 8-bit shift register, reset the baud counter, go to START. Otherwise stay, with tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the bit index. After bit 7 go to STOP. Bits go out LSB first.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- tx is registered (glitch-free). tx_busy = (state != IDLE).
- Latency: a push at edge N makes the FIFO non-empty after N. IDLE pops at edge N+1, and tx falls after edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back bytes have exactly one IDLE cycle between the stop bit and the next start bit.
- Baud counter counts 0..CLKS_PER_BIT-1. The state or bit advances on terminal count.

Decomposition:
- Shared package (uart_pkg): FSM state enum (IDLE/START/DATA/STOP), status bit-position constants (STAT_COUNT_LSB=0, STAT_EMPTY=6, STAT_FULL=7, STAT_BUSY=8, STAT_OVF=9), and default address constants.
- One sub-module, sync_fifo:
  - Parameterised width/depth.
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - Same clock/clear.
  - First-word-fall-through rdata, so IDLE can pop and load in one cycle.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4: tx=1, status=32'h0000_0040 (empty) for 100 cycles.
- Store 32'h0000_0155 to 8'hFF at edge N: tx falls after N+1. Sampling mid-bit gives 0,1,0,1,0,1,0,1,0,1 (start, 0x55 LSB first, stop). tx_busy is high for exactly 40 cycles.
- Nine back-to-back stores 0x30..0x38, depth 8:
  - The first byte pops at edge N+1, so all nine are accepted and overflow stays 0.
  - Each frame is 40 cycles and the next start bit follows one IDLE cycle after the previous stop bit.
- Pre-fill with FSM busy, depth 8: after 8 pushes, status[7]=1 and count=8. A 9th store sets overflow=1 and status[9]=1, and its byte is never transmitted. A store of 32'h200 to 8'hFE clears overflow.
- Full FIFO with a pop on the same edge as a push: the push is dropped, overflow=1, count goes 8 to 7.
- Assert clear mid-DATA bit 3 of 0xA5: tx=1 immediately, the FIFO empties, and status=32'h40. A later store of 0x41 transmits a clean frame.
